// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: control inputs and decoder-facing outputs of the step sequencer.
interface multicycle_sequencer_if #(parameter int RET_W = 16) ();
   logic             Start;
   logic             StepMode;
   logic             Step;
   logic             MemWait;
   logic [4:0]       InsM;
   logic [1:0]       InsL;
   logic [2:0]       Cnt;
   logic             Busy;
   logic             Halted;
   logic             Retire;
   logic [RET_W-1:0] RetireCount;
   modport master (
      input  Start, StepMode, Step, MemWait, InsM, InsL,
      output Cnt, Busy, Halted, Retire, RetireCount
   );
   modport slave (
      output Start, StepMode, Step, MemWait, InsM, InsL,
      input  Cnt, Busy, Halted, Retire, RetireCount
   );
endinterface

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: per-instruction step code generator with stalls, run/pause/halt and retire counting.
module multicycle_sequencer #(
   parameter int RET_W = 16
) (
   input logic                   Clk,
   input logic                   Rst,
   multicycle_sequencer_if.master bus
);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, HALT} state_t;
   state_t           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d, last;
   logic             retire_q, retire_d, busy_q, halted_q;
   logic [RET_W-1:0] count_q, count_d;
   logic             jmp, nop, hlt, cmp, st, stall;
   // Last-step decode; only meaningful from step 1 onward when the IR is loaded.
   always_comb begin
      jmp   = bus.InsM[4] && !bus.InsM[2];
      nop   = bus.InsM == 5'b11100 && !bus.InsL[0];
      hlt   = bus.InsM == 5'b11100 && bus.InsL == 2'b01;
      cmp   = bus.InsM == 5'b00110 && bus.InsL == 2'b01;
      st    = bus.InsM == 5'b00101 || (bus.InsM == 5'b00110 && bus.InsL == 2'b00);
      last  = (jmp || nop) ? 3'd1 : (hlt || cmp) ? 3'd2 : st ? 3'd3 : 3'd4;
      stall = bus.MemWait && (cnt_q == 3'd0 || cnt_q == 3'd3);
   end
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      retire_d = 1'b0;
      count_d  = count_q;
      case (state_q)
         IDLE: if (bus.Start) begin
            state_d = RUN;
            cnt_d   = 3'd0;
         end
         RUN: if (!stall) begin
            if (cnt_q == 3'd0 || cnt_q < last) cnt_d = cnt_q + 3'd1;
            else begin
               retire_d = 1'b1;
               count_d  = count_q + 1'b1;
               state_d  = hlt ? HALT : bus.StepMode ? PAUSE : RUN;
               cnt_d    = (hlt || bus.StepMode) ? 3'd7 : 3'd0;
            end
         end
         PAUSE: if (bus.Step) begin
            state_d = RUN;
            cnt_d   = 3'd0;
         end
         default: ;
      endcase
   end
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q  <= IDLE;
         cnt_q    <= 3'd7;
         retire_q <= 1'b0;
         count_q  <= '0;
         busy_q   <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         retire_q <= retire_d;
         count_q  <= count_d;
         busy_q   <= state_d == RUN;
         halted_q <= state_d == HALT;
      end
   end
   assign bus.Cnt         = cnt_q;
   assign bus.Busy        = busy_q;
   assign bus.Halted      = halted_q;
   assign bus.Retire      = retire_q;
   assign bus.RetireCount = count_q;
endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Step sequencer for the simplified multicycle 16-bit RISC processor. Generates the `Cnt[2:0]` step code consumed by the instruction decoder and advances it per instruction class. Handles:
- variable instruction length,
- memory wait stalls,
- run/halt/single-step control,
- retire counting.

It sits between the debug/top-level control inputs and the decoder.

## Interface
- `RET_W`, default 16: width of retired-instruction counter.
- `Clk`  input  1  system clock, rising edge.
- `Rst`  input  1  asynchronous, active-high reset.
- `Start`  input  1  one-cycle pulse; leaves IDLE and begins fetching.
- `StepMode`  input  1  1 = pause after every retired instruction.
- `Step`  input  1  one-cycle pulse; resumes from PAUSE for exactly one instruction.
- `MemWait`  input  1  memory not ready; stalls steps 0 and 3.
- `InsM`  input  5  instruction opcode bits [15:11] from the instruction register.
- `InsL`  input  2  instruction bits [1:0] from the instruction register.
- `Cnt`  output  3  registered step code to the decoder; 3'b111 = parked (decoder asserts nothing).
- `Busy`  output  1  registered; 1 in RUN.
- `Halted`  output  1  registered; 1 in HALT.
- `Retire`  output  1  registered one-cycle pulse per completed instruction.
- `RetireCount`  output  `RET_W`  registered count of retired instructions.

## Operation
States:
- IDLE: `Cnt`=7.
- RUN: `Cnt` in 0..4.
- PAUSE: `Cnt`=7.
- HALT: `Cnt`=7.

Reset (async, any state, mid-instruction included): state IDLE, `Cnt`=7, `Busy`=0, `Halted`=0, `Retire`=0, `RetireCount`=0.

State transitions:
- IDLE: `Start`=1 -> RUN, `Cnt`=0. `Step` is ignored. `Start`+`Step` together are treated as `Start`.

RUN sequencing:
- Step 0 is fetch. `InsM`/`InsL` are not valid at step 0, so 0 always advances to 1, unless `MemWait`.
- From step 1 on, the last step L is decoded from the current `InsM`/`InsL`:
  - `{InsM[15],InsM[13]}`=2'b10 (jump/branch/link): L=1.
  - `InsM`=5'b11100, `InsL[0]`=0 (NOP): L=1.
  - `InsM`=5'b11100, `InsL`=2'b01 (HLT): terminates at step 2.
  - `InsM`=5'b00110, `InsL`=2'b01 (CMP): L=2.
  - `InsM`=5'b00101, or `InsM`=5'b00110 with `InsL`=2'b00 (stores): L=3.
  - All others: L=4.
  - The first matching rule wins.
- Within RUN:
  - `Cnt` < L: `Cnt`+1.
  - `Cnt` == L: instruction retires. Next `Cnt`=0, or PAUSE if `StepMode`=1.
- HLT at step 2: next state HALT, `Halted`=1, `Busy`=0, `Retire` pulses, count increments.
- `MemWait`=1 while `Cnt` is 0 or 3: hold `Cnt`, no retire. `MemWait` at other steps is ignored.
- Retire at step 3 (stores) with `MemWait`=1: retire is deferred until `MemWait`=0.

Other states:
- PAUSE: `Step`=1 -> RUN, `Cnt`=0. `Start` is ignored.
- HALT: absorbing; only `Rst` exits. `Start`/`Step` are ignored.
- `StepMode` is sampled only at retire; changing it mid-instruction has no effect until then.

Counter and pulses:
- `RetireCount` wraps all-ones -> 0.
- `Retire` and the count update occur on the same edge that leaves the last step.
- `Step` pulses while in RUN are dropped, not queued.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- `Start` sampled at edge t gives `Cnt`=0 at t+1.
- Instruction latency is L+1 cycles plus stall cycles:
  - jump: 2 cycles.
  - CMP: 3 cycles.
  - store: 4 cycles.
  - ALU/load: 5 cycles.
  - HLT: 3 cycles to `Halted`.
- `Retire` is high for exactly one cycle: the cycle after the last step, coincident with the new `Cnt`=0, or with 7 if pausing.
- PAUSE -> RUN: `Step` at edge t gives `Cnt`=0 at t+1.
- Throughput in RUN: back-to-back instructions with no idle cycle between the last step and the next fetch.

## Test plan
- Reset then `Start`, ALU op (`InsM`=00000) -> `Cnt` sequence 7,0,1,2,3,4,0. `Retire` pulses once. `RetireCount`=1.
- Jump (`InsM`=10000) then store (`InsM`=00101) -> `Cnt` 0,1,0,1,2,3,0. Two `Retire` pulses. Count=2.
- `MemWait`=1 for 3 cycles at step 0, then 2 cycles at step 3 of a load -> `Cnt` holds 0 for 3 cycles and 3 for 2 cycles. Total 10 cycles to retire.
- `StepMode`=1, CMP (`InsM`=00110, `InsL`=01) -> `Cnt` 0,1,2,7 and stays 7. `Step` pulse -> `Cnt`=0 next cycle. A `Step` pulse during RUN is ignored.
- HLT (`InsM`=11100, `InsL`=01) -> `Cnt` 0,1,2,7; `Halted`=1; `Retire` pulses. Subsequent `Start`/`Step` give no change.
- `RetireCount` preset near 16'hFFFF via 65535 NOPs, or `RET_W`=2 with 4 NOPs -> count wraps to 0. `Rst` asserted at step 3 -> same-cycle `Cnt`=7, count=0, state IDLE.
